// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter slice: FSM state
// encoding, BCD register width and the fixed result codes.
package bcd_pkg;

  // Converter control states.
  typedef enum logic [1:0] {
    INACTIVO = 2'd0,
    DESPLAZA = 2'd1,
    FIN      = 2'd2
  } estado_t;

  // Three BCD digits hold any 8-bit input (max 255).
  localparam int ANCHO_BCD = 12;

  // Displayed value when the result is pinned at the top of the two-digit range.
  localparam logic [7:0] BCD_SATURADO = 8'h99;

  // Displayed value out of reset.
  localparam logic [7:0] BCD_CERO = 8'h00;

endpackage

// File: rtl/conv_bin_bcd_if.sv
// Start/done handshake between a binary value source and the BCD converter.
// The master drives the request and value; the slave (converter) returns
// busy, the one-cycle done pulse and the packed two-digit result.
interface conv_bin_bcd_if #(
  parameter int ANCHO_BIN = 8
) ();

  logic                 inicio;
  logic [ANCHO_BIN-1:0] binario;
  logic                 ocupado;
  logic                 listo;
  logic [7:0]           dato;
  logic                 desborde;

  modport master (
    output inicio,
    output binario,
    input  ocupado,
    input  listo,
    input  dato,
    input  desborde
  );

  modport slave (
    input  inicio,
    input  binario,
    output ocupado,
    output listo,
    output dato,
    output desborde
  );

endinterface

// File: rtl/ajuste_bcd.sv
// Double-dabble correction step: every BCD nibble that is 5 or more gets +3
// so that the following left shift carries correctly into the next digit.
// Each nibble is adjusted independently; there is no carry between nibbles.
module ajuste_bcd
  import bcd_pkg::*;
(
  input  logic [ANCHO_BCD-1:0] entrada,
  output logic [ANCHO_BCD-1:0] salida
);

  // Per-nibble add-3 correction.
  always_comb begin
    // NOTE: default the whole output first so that no path leaves it unassigned (no latch).
    salida = entrada;
    for (int i = 0; i < ANCHO_BCD / 4; i++) begin
      if (entrada[4*i +: 4] >= 4'd5) begin
        salida[4*i +: 4] = entrada[4*i +: 4] + 4'd3;
      end
    end
  end

endmodule

// File: rtl/conv_bin_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Produces the packed two-digit BCD byte (tens:units) for the character
// address decoder, with an overflow flag for values above 99.
// Optional build macro SATURA_BCD_EN: when defined, results above 99 are
// shown as 99 instead of their low two digits.
module conv_bin_bcd
  import bcd_pkg::*;
#(
  parameter int ANCHO_BIN = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  conv_bin_bcd_if.slave bus
);

  localparam int ANCHO_CNT = $clog2(ANCHO_BIN + 1);

  estado_t                       estado;
  logic [ANCHO_BIN-1:0]          bin_reg;
  logic [ANCHO_BCD-1:0]          bcd_reg;
  logic [ANCHO_BCD-1:0]          bcd_ajustado;
  logic [ANCHO_CNT-1:0]          cnt;
  logic [ANCHO_BCD+ANCHO_BIN-1:0] desplazado;
  logic [7:0]                    dato_siguiente;
  logic [7:0]                    dato_q;
  logic                          desborde_q;
  logic                          ocupado_q;
  logic                          listo_q;

  ajuste_bcd u_ajuste (
    .entrada (bcd_reg),
    .salida  (bcd_ajustado)
  );

  // Corrected BCD digits and remaining binary bits move left as one register.
  assign desplazado = {bcd_ajustado, bin_reg} << 1;

  // Value presented on the done edge: low two digits, or pinned at 99.
  always_comb begin
    dato_siguiente = bcd_reg[7:0];
`ifdef SATURA_BCD_EN
    if (bcd_reg[ANCHO_BCD-1:8] != 4'd0) begin
      dato_siguiente = BCD_SATURADO;
    end
`else
    dato_siguiente = bcd_reg[7:0];
`endif
  end

  // Control FSM with registered handshake outputs and conversion datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado     <= INACTIVO;
      bin_reg    <= '0;
      bcd_reg    <= '0;
      cnt        <= '0;
      ocupado_q  <= 1'b0;
      listo_q    <= 1'b0;
      dato_q     <= BCD_CERO;
      desborde_q <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
      listo_q <= 1'b0;
      case (estado)
        INACTIVO: begin
          if (bus.inicio) begin
            bin_reg   <= bus.binario;
            bcd_reg   <= '0;
            cnt       <= ANCHO_CNT'(ANCHO_BIN);
            ocupado_q <= 1'b1;
            estado    <= DESPLAZA;
          end
        end
        DESPLAZA: begin
          bcd_reg <= desplazado[ANCHO_BCD+ANCHO_BIN-1:ANCHO_BIN];
          bin_reg <= desplazado[ANCHO_BIN-1:0];
          cnt     <= cnt - ANCHO_CNT'(1);
          if (cnt == ANCHO_CNT'(1)) begin
            estado <= FIN;
          end
        end
        FIN: begin
          dato_q     <= dato_siguiente;
          desborde_q <= (bcd_reg[ANCHO_BCD-1:8] != 4'd0);
          listo_q    <= 1'b1;
          ocupado_q  <= 1'b0;
          estado     <= INACTIVO;
        end
        default: begin
          estado <= INACTIVO;
        end
      endcase
    end
  end

  assign bus.ocupado  = ocupado_q;
  assign bus.listo    = listo_q;
  assign bus.dato     = dato_q;
  assign bus.desborde = desborde_q;

endmodule

// File: tb/tb_conv_bin_bcd.sv
// Directed bench for the binary-to-BCD converter: reset state, nominal
// values, overflow, ignored requests, back-to-back, mid-conversion reset,
// the correction stage on its own, and a full 0..255 sweep.
module tb_conv_bin_bcd;
  import bcd_pkg::*;

  localparam int ANCHO_BIN = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  conv_bin_bcd_if #(.ANCHO_BIN(ANCHO_BIN)) bus ();

  conv_bin_bcd #(.ANCHO_BIN(ANCHO_BIN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [ANCHO_BCD-1:0] aj_in;
  logic [ANCHO_BCD-1:0] aj_out;

  ajuste_bcd u_aj (
    .entrada (aj_in),
    .salida  (aj_out)
  );

  always #5 clk = ~clk;

  // Decimal reference: digits by division, independent of the shift algorithm.
  function automatic logic [7:0] ref_dato(input int v);
    logic [3:0] dec;
    logic [3:0] uni;
    dec = 4'((v / 10) % 10);
    uni = 4'(v % 10);
`ifdef SATURA_BCD_EN
    if (v > 99) return 8'h99;
`endif
    return {dec, uni};
  endfunction

  // Present a request for one cycle; returns at the negedge after the accept edge.
  task automatic start_conv(input logic [7:0] valor);
    bus.inicio  = 1'b1;
    bus.binario = valor;
    @(negedge clk);
    bus.inicio  = 1'b0;
  endtask

  // Wait for listo (bounded); report cycles waited, busy samples and overlaps.
  task automatic wait_listo(output int lat, output int occ, output int solape);
    lat = 0;
    occ = 0;
    solape = 0;
    while (lat < 30) begin
      if (bus.ocupado) occ++;
      if (bus.ocupado && bus.listo) solape++;
      if (bus.listo) break;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 20; i++) begin
      tests_run++;
      if (bus.dato !== 8'h00 || bus.desborde !== 1'b0 || bus.ocupado !== 1'b0 || bus.listo !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_idle cyc=%0d got dato=%h desb=%b ocu=%b listo=%b want 00/0/0/0",
                 i, bus.dato, bus.desborde, bus.ocupado, bus.listo);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ajuste;
    logic [11:0] vin [4]  = '{12'h000, 12'h555, 12'h456, 12'h934};
    logic [11:0] vexp [4] = '{12'h000, 12'h888, 12'h489, 12'hC34};
    for (int i = 0; i < 4; i++) begin
      aj_in = vin[i];
      #1;
      tests_run++;
      if (aj_out !== vexp[i]) begin
        tests_failed++;
        $display("FAIL ajuste in=%h got %h want %h", vin[i], aj_out, vexp[i]);
      end
    end
  endtask

  // One conversion with full checks of latency, busy, pulse width and result.
  task automatic conv_check(input string nombre, input logic [7:0] valor,
                            input logic [7:0] exp_dato, input logic exp_desb);
    int lat, occ, sol;
    start_conv(valor);
    wait_listo(lat, occ, sol);
    tests_run++;
    if (lat !== 9 || occ !== 9 || sol !== 0) begin
      tests_failed++;
      $display("FAIL %s timing got lat=%0d ocu=%0d overlap=%0d want 9/9/0", nombre, lat, occ, sol);
    end
    tests_run++;
    if (bus.dato !== exp_dato || bus.desborde !== exp_desb) begin
      tests_failed++;
      $display("FAIL %s result got dato=%h desb=%b want %h/%b", nombre, bus.dato, bus.desborde, exp_dato, exp_desb);
    end
    @(negedge clk);
    tests_run++;
    if (bus.listo !== 1'b0 || bus.dato !== exp_dato || bus.desborde !== exp_desb) begin
      tests_failed++;
      $display("FAIL %s hold got listo=%b dato=%h desb=%b want 0/%h/%b", nombre, bus.listo, bus.dato, bus.desborde, exp_dato, exp_desb);
    end
  endtask

  task automatic test_basico;
    conv_check("conv_42", 8'd42, 8'h42, 1'b0);
    conv_check("conv_0",  8'd0,  8'h00, 1'b0);
    conv_check("conv_99", 8'd99, 8'h99, 1'b0);
  endtask

  task automatic test_desborde;
`ifdef SATURA_BCD_EN
    conv_check("conv_150", 8'd150, 8'h99, 1'b1);
    conv_check("conv_100", 8'd100, 8'h99, 1'b1);
    conv_check("conv_255", 8'd255, 8'h99, 1'b1);
`else
    conv_check("conv_150", 8'd150, 8'h50, 1'b1);
    conv_check("conv_100", 8'd100, 8'h00, 1'b1);
    conv_check("conv_255", 8'd255, 8'h55, 1'b1);
`endif
  endtask

  task automatic test_back_to_back;
    int lat, occ, sol;
    start_conv(8'd37);
    repeat (3) @(negedge clk);
    // Request while busy: must be dropped, not queued.
    start_conv(8'd88);
    wait_listo(lat, occ, sol);
    tests_run++;
    if (lat !== 5 || bus.dato !== 8'h37 || bus.desborde !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignore_busy got lat=%0d dato=%h desb=%b want 5/37/0", lat, bus.dato, bus.desborde);
    end
    // Request in the listo cycle: accepted immediately.
    start_conv(8'd88);
    wait_listo(lat, occ, sol);
    tests_run++;
    if (lat !== 9 || occ !== 9 || bus.dato !== 8'h88 || bus.desborde !== 1'b0) begin
      tests_failed++;
      $display("FAIL back_to_back got lat=%0d ocu=%0d dato=%h desb=%b want 9/9/88/0", lat, occ, bus.dato, bus.desborde);
    end
    @(negedge clk);
    // No stale conversion of the dropped 88 follows.
    repeat (12) begin
      tests_run++;
      if (bus.listo !== 1'b0 || bus.ocupado !== 1'b0) begin
        tests_failed++;
        $display("FAIL no_queue got listo=%b ocu=%b want 0/0", bus.listo, bus.ocupado);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    start_conv(8'd64);
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (bus.dato !== 8'h00 || bus.desborde !== 1'b0 || bus.ocupado !== 1'b0 || bus.listo !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async got dato=%h desb=%b ocu=%b listo=%b want 00/0/0/0",
               bus.dato, bus.desborde, bus.ocupado, bus.listo);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tests_run++;
      if (bus.listo !== 1'b0 || bus.ocupado !== 1'b0 || bus.dato !== 8'h00) begin
        tests_failed++;
        $display("FAIL reset_discard cyc=%0d got listo=%b ocu=%b dato=%h want 0/0/00", i, bus.listo, bus.ocupado, bus.dato);
      end
      @(negedge clk);
    end
    conv_check("conv_12_after_reset", 8'd12, 8'h12, 1'b0);
  endtask

  task automatic test_barrido;
    int lat, occ, sol;
    logic [7:0] esp;
    for (int v = 0; v < 256; v++) begin
      esp = ref_dato(v);
      start_conv(8'(v));
      wait_listo(lat, occ, sol);
      tests_run++;
      if (bus.dato !== esp || bus.desborde !== (v > 99)) begin
        tests_failed++;
        $display("FAIL sweep_result v=%0d got dato=%h desb=%b want %h/%b", v, bus.dato, bus.desborde, esp, (v > 99));
      end
      tests_run++;
      if (bus.dato[7:4] > 4'd9 || bus.dato[3:0] > 4'd9) begin
        tests_failed++;
        $display("FAIL sweep_digits v=%0d got dato=%h want nibbles <= 9", v, bus.dato);
      end
      tests_run++;
      if (lat !== 9 || sol !== 0) begin
        tests_failed++;
        $display("FAIL sweep_latency v=%0d got lat=%0d overlap=%0d want 9/0", v, lat, sol);
      end
    end
  endtask

  initial begin
    bus.inicio  = 1'b0;
    bus.binario = '0;
    aj_in       = '0;
    reset_n     = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_ajuste();
    test_basico();
    test_back_to_back();
    test_desborde();
    test_reset_mid();
    test_barrido();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
